// File: rtl/vga_pkg.sv
// Shared VGA timing types and the two standard mode tables.
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_total;
    logic [15:0] h_sync_start;
    logic [15:0] h_sync_end;
    logic        h_pol;
    logic [15:0] v_active;
    logic [15:0] v_total;
    logic [15:0] v_sync_start;
    logic [15:0] v_sync_end;
    logic        v_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_MODE_1024X768 = '{
    h_active: 16'd1024, h_total: 16'd1344, h_sync_start: 16'd1048, h_sync_end: 16'd1183,
    h_pol: 1'b0,
    v_active: 16'd768, v_total: 16'd806, v_sync_start: 16'd771, v_sync_end: 16'd776,
    v_pol: 1'b0
  };

  localparam vga_mode_t VGA_MODE_800X600 = '{
    h_active: 16'd800, h_total: 16'd1056, h_sync_start: 16'd840, h_sync_end: 16'd967,
    h_pol: 1'b1,
    v_active: 16'd600, v_total: 16'd628, v_sync_start: 16'd601, v_sync_end: 16'd604,
    v_pol: 1'b1
  };

endpackage

// File: rtl/vga_sync_decode.sv
// Combinational decode of a raster position into sync and blanking levels.
import vga_pkg::*;

module vga_sync_decode #(
  parameter int unsigned H_CNT_W = 11,
  parameter int unsigned V_CNT_W = 10
) (
  input  logic [H_CNT_W-1:0] hcount,
  input  logic [V_CNT_W-1:0] vcount,
  input  vga_mode_t          mode,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk
);

  logic [15:0] h_pos;
  logic [15:0] v_pos;

  // Totals belong to the counter logic in the top level, not to this decode.
  logic unused_totals;
  assign unused_totals = ^{mode.h_total, mode.v_total};

  // Inclusive sync windows driven at the mode's polarity; blanking past the active area.
  always_comb begin
    h_pos = 16'(hcount);
    v_pos = 16'(vcount);
    hsync = ((h_pos >= mode.h_sync_start) && (h_pos <= mode.h_sync_end)) ? mode.h_pol : ~mode.h_pol;
    vsync = ((v_pos >= mode.v_sync_start) && (v_pos <= mode.v_sync_end)) ? mode.v_pol : ~mode.v_pol;
    hblnk = (h_pos >= mode.h_active);
    vblnk = (v_pos >= mode.v_active);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with two modes switched only at the frame wrap.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int unsigned H_CNT_W    = 11,
  parameter int unsigned V_CNT_W    = 10,
  parameter vga_mode_t   MODE0      = VGA_MODE_1024X768,
  parameter vga_mode_t   MODE1      = VGA_MODE_800X600,
  parameter logic        RESET_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_sel,
  output logic [H_CNT_W-1:0] hcount,
  output logic [V_CNT_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               frame_start,
  output logic               mode_active
);

  localparam vga_mode_t RST_CFG = RESET_MODE ? MODE1 : MODE0;

  vga_mode_t          cur_cfg;
  vga_mode_t          nxt_cfg;
  logic               line_end;
  logic               frame_end;
  logic               mode_nxt;
  logic [H_CNT_W-1:0] hcount_nxt;
  logic [V_CNT_W-1:0] vcount_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               hblnk_nxt;
  logic               vblnk_nxt;

  // Next-state counters and mode; the mode only changes on the frame-wrap edge.
  always_comb begin
    cur_cfg    = mode_active ? MODE1 : MODE0;
    line_end   = (hcount == H_CNT_W'(cur_cfg.h_total - 16'd1));
    frame_end  = line_end && (vcount == V_CNT_W'(cur_cfg.v_total - 16'd1));
    mode_nxt   = frame_end ? mode_sel : mode_active;
    hcount_nxt = line_end ? '0 : hcount + H_CNT_W'(1);
    vcount_nxt = vcount;
    if (line_end) begin
      vcount_nxt = frame_end ? '0 : vcount + V_CNT_W'(1);
    end
    nxt_cfg    = mode_nxt ? MODE1 : MODE0;
  end

  // Decoding the next-state position keeps syncs and blanks aligned with the counters.
  vga_sync_decode #(
    .H_CNT_W (H_CNT_W),
    .V_CNT_W (V_CNT_W)
  ) u_decode (
    .hcount (hcount_nxt),
    .vcount (vcount_nxt),
    .mode   (nxt_cfg),
    .hsync  (hsync_nxt),
    .vsync  (vsync_nxt),
    .hblnk  (hblnk_nxt),
    .vblnk  (vblnk_nxt)
  );

  // Output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~RST_CFG.h_pol;
      vsync       <= ~RST_CFG.v_pol;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= RESET_MODE;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      frame_start <= frame_end;
      mode_active <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-parameter instance checks the 1024x768 line timing; a small-mode
// instance exercises frame wraps, mode switching and mid-frame reset.
import vga_pkg::*;

module tb_vga_timing_gen;

  localparam vga_mode_t TB_M0 = '{
    h_active: 16'd20, h_total: 16'd28, h_sync_start: 16'd22, h_sync_end: 16'd25, h_pol: 1'b0,
    v_active: 16'd10, v_total: 16'd14, v_sync_start: 16'd11, v_sync_end: 16'd12, v_pol: 1'b0
  };
  localparam vga_mode_t TB_M1 = '{
    h_active: 16'd16, h_total: 16'd22, h_sync_start: 16'd17, h_sync_end: 16'd19, h_pol: 1'b1,
    v_active: 16'd8, v_total: 16'd11, v_sync_start: 16'd9, v_sync_end: 16'd9, v_pol: 1'b1
  };

  // Reference timing tables: index 0/1 = small test modes, 2 = 1024x768.
  int ht[3] = '{28, 22, 1344};
  int ha[3] = '{20, 16, 1024};
  int hs[3] = '{22, 17, 1048};
  int he[3] = '{25, 19, 1183};
  int hp[3] = '{0, 1, 0};
  int vt[3] = '{14, 11, 806};
  int va[3] = '{10, 8, 768};
  int vs[3] = '{11, 9, 771};
  int ve[3] = '{12, 9, 776};
  int vp[3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n;
  logic mode_sel;
  logic mode_sel_a;

  logic [10:0] hcount_a, hcount_b;
  logic [9:0]  vcount_a, vcount_b;
  logic hsync_a, vsync_a, hblnk_a, vblnk_a, fs_a, ma_a;
  logic hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b, ma_b;

  int vectors = 0;
  int miscompares = 0;

  // Model state: frame-linear pixel index, mode index and strobe expectation.
  int pos_a, pos_b, mode_b, fs_exp_b;
  int hsync_low_a;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk (clk), .rst_n (rst_n), .mode_sel (mode_sel_a),
    .hcount (hcount_a), .vcount (vcount_a), .hsync (hsync_a), .vsync (vsync_a),
    .hblnk (hblnk_a), .vblnk (vblnk_a), .frame_start (fs_a), .mode_active (ma_a)
  );

  vga_timing_gen #(
    .H_CNT_W (11), .V_CNT_W (10), .MODE0 (TB_M0), .MODE1 (TB_M1), .RESET_MODE (1'b0)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .mode_sel (mode_sel),
    .hcount (hcount_b), .vcount (vcount_b), .hsync (hsync_b), .vsync (vsync_b),
    .hblnk (hblnk_b), .vblnk (vblnk_b), .frame_start (fs_b), .mode_active (ma_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int in_win(int c, int lo, int hi, int pol);
    return ((c >= lo) && (c <= hi)) ? pol : 1 - pol;
  endfunction

  task automatic check_a();
    int h, v;
    h = pos_a % ht[2];
    v = pos_a / ht[2];
    chk("a_hcount", int'(hcount_a), h);
    chk("a_vcount", int'(vcount_a), v);
    chk("a_hsync", int'(hsync_a), in_win(h, hs[2], he[2], hp[2]));
    chk("a_vsync", int'(vsync_a), in_win(v, vs[2], ve[2], vp[2]));
    chk("a_hblnk", int'(hblnk_a), (h >= ha[2]) ? 1 : 0);
    chk("a_vblnk", int'(vblnk_a), (v >= va[2]) ? 1 : 0);
    chk("a_frame_start", int'(fs_a), 0);
    chk("a_mode_active", int'(ma_a), 0);
  endtask

  task automatic check_b();
    int h, v;
    h = pos_b % ht[mode_b];
    v = pos_b / ht[mode_b];
    chk("b_hcount", int'(hcount_b), h);
    chk("b_vcount", int'(vcount_b), v);
    chk("b_hsync", int'(hsync_b), in_win(h, hs[mode_b], he[mode_b], hp[mode_b]));
    chk("b_vsync", int'(vsync_b), in_win(v, vs[mode_b], ve[mode_b], vp[mode_b]));
    chk("b_hblnk", int'(hblnk_b), (h >= ha[mode_b]) ? 1 : 0);
    chk("b_vblnk", int'(vblnk_b), (v >= va[mode_b]) ? 1 : 0);
    chk("b_frame_start", int'(fs_b), fs_exp_b);
    chk("b_mode_active", int'(ma_b), mode_b);
  endtask

  task automatic model_reset();
    pos_a = 0;
    pos_b = 0;
    mode_b = 0;
    fs_exp_b = 0;
  endtask

  // One clock: advance both models with the inputs seen at the edge, then check.
  task automatic step();
    int sel;
    @(posedge clk);
    sel = int'(mode_sel);
    if (rst_n === 1'b1) begin
      pos_a = (pos_a == ht[2] * vt[2] - 1) ? 0 : pos_a + 1;
      if (pos_b == ht[mode_b] * vt[mode_b] - 1) begin
        pos_b = 0;
        mode_b = sel;
        fs_exp_b = 1;
      end else begin
        pos_b = pos_b + 1;
        fs_exp_b = 0;
      end
    end
    #1;
    check_a();
    check_b();
    if (hsync_a === 1'b0 && vcount_a == 10'd0) hsync_low_a++;
  endtask

  task automatic run_to_wrap(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (fs_exp_b == 0 && n < 2000);
    chk({tag, "_wrap_seen"}, int'(fs_b), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    mode_sel = 1'b0;
    mode_sel_a = 1'b0;
    hsync_low_a = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_a();
    check_b();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // Three full 1024x768 lines plus all of several small frames in mode 0.
    for (int i = 0; i < 3 * 1344 + 10; i++) step();
    chk("a_hsync_low_cycles_line0", hsync_low_a, 136);

    // Short mode_sel pulse that ends well before the wrap is ignored.
    mode_sel = 1'b1;
    step(); step(); step();
    mode_sel = 1'b0;
    run_to_wrap("pulse");
    chk("pulse_mode_stays_0", int'(ma_b), 0);

    // Mid-frame request takes effect only at the wrap.
    for (int i = 0; i < 100; i++) step();
    mode_sel = 1'b1;
    for (int i = 0; i < 50; i++) step();
    chk("switch_before_wrap", int'(ma_b), 0);
    run_to_wrap("switch");
    chk("switch_mode_1", int'(ma_b), 1);
    for (int i = 0; i < 2 * 242; i++) step();

    // Random mode_sel every cycle; only the wrap-cycle value may matter.
    for (int i = 0; i < 4000; i++) begin
      mode_sel = 1'($urandom_range(0, 1));
      step();
    end

    // Asynchronous reset in the middle of a frame.
    mode_sel = 1'b0;
    begin
      int n;
      n = 0;
      while (!((pos_b % ht[mode_b]) == 5 && (pos_b / ht[mode_b]) == 3) && n < 2000) begin
        step();
        n++;
      end
      chk("reset_point_reached", n < 2000 ? 1 : 0, 1);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_hcount", int'(hcount_b), 0);
    chk("rst_async_frame_start", int'(fs_b), 0);
    check_a();
    check_b();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      mode_sel = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
